// File: rtl/led_frame_shifter.sv
// Snapshots framebuf and shifts it MSB first into daisy-chained LED drivers.
// Optional LEDSHIFT_CHANGE_DETECT_EN: after the first frame, reshift only on change.
module led_frame_shifter #(
  parameter int FB_WIDTH   = 384,
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 16
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic [FB_WIDTH-1:0] framebuf,
  output logic                led_sclk,
  output logic                led_sdata,
  output logic                led_latch,
  output logic                led_oe_n,
  output logic                busy
);

  localparam int CW = (FB_WIDTH > 1) ? $clog2(FB_WIDTH) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(FB_WIDTH - 1);
  localparam logic [DW-1:0] DIV_TOP = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_TOP =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, GAP} state_e;

  state_e              state_q, state_d;
  logic [DW-1:0]       div_q, div_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic [FB_WIDTH-1:0] snap_q, snap_d;
  logic                sclk_q, sclk_d;
  logic                sdata_q, sdata_d;
  logic                latch_q, latch_d;
  logic                oe_n_q, oe_n_d;
  logic                busy_q, busy_d;
  logic [CW-1:0]       cnt_dec;
  logic                start;

  assign cnt_dec = cnt_q - CW'(1);

  // oe_n still high means no frame has latched since reset
  always_comb begin
`ifdef LEDSHIFT_CHANGE_DETECT_EN
    start = oe_n_q || (framebuf != snap_q);
`else
    start = 1'b1;
`endif
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    snap_d  = snap_q;
    sclk_d  = sclk_q;
    sdata_d = sdata_q;
    latch_d = latch_q;
    oe_n_d  = oe_n_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          snap_d  = framebuf;
          cnt_d   = CNT_TOP;
          div_d   = '0;
          busy_d  = 1'b1;
          sclk_d  = 1'b0;
          sdata_d = framebuf[FB_WIDTH-1];
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (div_q == DIV_TOP) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (cnt_q == '0) begin
              latch_d = 1'b1;
              state_d = LATCH;
            end else begin
              cnt_d   = cnt_dec;
              sdata_d = snap_q[cnt_dec];
            end
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      LATCH: begin
        if (div_q == DIV_TOP) begin
          div_d   = '0;
          latch_d = 1'b0;
          oe_n_d  = 1'b0;
          gap_d   = '0;
          if (GAP_CYCLES == 0) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = GAP;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      GAP: begin
        if (gap_q == GAP_TOP) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      snap_q  <= '0;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
      latch_q <= 1'b0;
      oe_n_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      snap_q  <= snap_d;
      sclk_q  <= sclk_d;
      sdata_q <= sdata_d;
      latch_q <= latch_d;
      oe_n_q  <= oe_n_d;
      busy_q  <= busy_d;
    end
  end

  assign led_sclk  = sclk_q;
  assign led_sdata = sdata_q;
  assign led_latch = latch_q;
  assign led_oe_n  = oe_n_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_led_frame_shifter.sv
// Scoreboard bench for led_frame_shifter: three configurations run in parallel,
// each frame captured on sclk rises and checked at the latch strobe.
module tb_led_frame_shifter;

`ifdef LEDSHIFT_CHANGE_DETECT_EN
  localparam bit CONT = 1'b0;
`else
  localparam bit CONT = 1'b1;
`endif

  function automatic int p_w(int k);
    return (k == 2) ? 384 : 8;
  endfunction
  function automatic int p_cd(int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 4;
  endfunction
  function automatic int p_g(int k);
    return (k == 0) ? 3 : (k == 1) ? 0 : 16;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [383:0] fb [3];
  logic nrst [3];
  logic sclk [3];
  logic sdata [3];
  logic latch [3];
  logic oe_n [3];
  logic busy [3];
  int frames_done [3];
  int rises [3];
  int tests;
  int fails;

  logic [383:0] q0 [$];
  logic [383:0] q1 [$];
  logic [383:0] q2 [$];

  task automatic push(input int k, input logic [383:0] v);
    case (k)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  function automatic int qsize(int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [383:0] qpop(int k);
    case (k)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic chk(input bit ok, input string nm,
                     input logic [383:0] act, input logic [383:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  for (genvar k = 0; k < 3; k++) begin : g
    localparam int W  = p_w(k);
    localparam int CD = p_cd(k);
    localparam int G  = p_g(k);
    localparam int P  = 1 + 2 * CD * W + CD + G;
    localparam logic [383:0] M =
      (W == 384) ? {384{1'b1}} : ((384'd1 << W) - 384'd1);

    led_frame_shifter #(
      .FB_WIDTH  (W),
      .CLK_DIV   (CD),
      .GAP_CYCLES(G)
    ) u_dut (
      .clk      (clk),
      .nrst     (nrst[k]),
      .framebuf (fb[k][W-1:0]),
      .led_sclk (sclk[k]),
      .led_sdata(sdata[k]),
      .led_latch(latch[k]),
      .led_oe_n (oe_n[k]),
      .busy     (busy[k])
    );

    initial begin : mon
      int cyc, nbits, last_rise, lat_start, prev_lat, low_len;
      bit ps, pl, pb, first, low_valid;
      logic [383:0] sh, e;
      cyc = 0; nbits = 0; last_rise = 0; lat_start = 0;
      prev_lat = -1; low_len = 0;
      ps = 0; pl = 0; pb = 0; first = 1; low_valid = 0;
      sh = '0; e = '0;
      forever begin
        @(negedge clk);
        cyc++;
        if (!nrst[k]) begin
          nbits = 0; sh = '0; prev_lat = -1; first = 1;
          low_valid = 0; ps = 0; pl = 0; pb = 0;
        end else begin
          if (sclk[k] && !ps) begin
            if (nbits > 0)
              chk(cyc - last_rise == 2 * CD,
                  $sformatf("d%0d_sclk_period", k), cyc - last_rise, 2 * CD);
            last_rise = cyc;
            sh = {sh[382:0], sdata[k]};
            nbits++;
            rises[k]++;
          end
          if (latch[k])
            chk(sclk[k] == 1'b0, $sformatf("d%0d_sclk_in_latch", k),
                sclk[k], 0);
          if (latch[k] && !pl) begin
            lat_start = cyc;
            if (first)
              chk(oe_n[k] == 1'b1, $sformatf("d%0d_oe_before_latch", k),
                  oe_n[k], 1);
            if (CONT && prev_lat >= 0)
              chk(cyc - prev_lat == P, $sformatf("d%0d_frame_period", k),
                  cyc - prev_lat, P);
            prev_lat = cyc;
            chk(nbits == W, $sformatf("d%0d_bit_count", k), nbits, W);
            if (qsize(k) == 0) begin
              chk(1'b0, $sformatf("d%0d_unexpected_frame", k), sh & M, 0);
            end else begin
              e = qpop(k);
              chk((sh & M) == (e & M), $sformatf("d%0d_frame_data", k),
                  sh & M, e & M);
            end
            nbits = 0;
            sh = '0;
            frames_done[k]++;
          end
          if (!latch[k] && pl) begin
            chk(cyc - lat_start == CD, $sformatf("d%0d_latch_width", k),
                cyc - lat_start, CD);
            chk(oe_n[k] == 1'b0, $sformatf("d%0d_oe_after_latch", k),
                oe_n[k], 0);
            first = 0;
          end
          if (!busy[k]) begin
            if (pb) begin
              low_len = 0;
              low_valid = 1;
            end
            low_len++;
          end else if (!pb && low_valid && CONT) begin
            chk(low_len == 1, $sformatf("d%0d_busy_low", k), low_len, 1);
          end
          ps = sclk[k];
          pl = latch[k];
          pb = busy[k];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frames(input int k, input int n, input int budget);
    int t;
    t = 0;
    while (frames_done[k] < n && t < budget) begin
      tick();
      t++;
    end
    chk(frames_done[k] >= n, $sformatf("d%0d_wait_frame%0d", k, n),
        frames_done[k], n);
  endtask

  task automatic wait_start(input int k, input int budget);
    int t;
    t = 0;
    while (busy[k] && t < budget) begin
      tick();
      t++;
    end
    while (!busy[k] && t < budget) begin
      tick();
      t++;
    end
    chk(busy[k] == 1'b1, $sformatf("d%0d_wait_start", k), busy[k], 1);
  endtask

  task automatic chk_reset(input int k, input string tag);
    chk(sclk[k] == 1'b0, {tag, "_sclk"}, sclk[k], 0);
    chk(sdata[k] == 1'b0, {tag, "_sdata"}, sdata[k], 0);
    chk(latch[k] == 1'b0, {tag, "_latch"}, latch[k], 0);
    chk(oe_n[k] == 1'b1, {tag, "_oe_n"}, oe_n[k], 1);
    chk(busy[k] == 1'b0, {tag, "_busy"}, busy[k], 0);
  endtask

  task automatic release_rst(input int k);
    @(negedge clk);
    nrst[k] = 1'b1;
    tick();
    chk(busy[k] == 1'b1, $sformatf("d%0d_first_start", k), busy[k], 1);
    chk(oe_n[k] == 1'b1, $sformatf("d%0d_oe_held", k), oe_n[k], 1);
  endtask

  task automatic stim0();
    int r;
    repeat (3) tick();
    chk_reset(0, "d0_reset");
`ifdef LEDSHIFT_CHANGE_DETECT_EN
    fb[0] = 384'h0F;
    push(0, 384'h0F);
    release_rst(0);
    wait_frames(0, 1, 200);
    r = rises[0];
    repeat (200) tick();
    chk(rises[0] == r, "d0_no_sclk", rises[0], r);
    chk(frames_done[0] == 1, "d0_single_frame", frames_done[0], 1);
    chk(busy[0] == 1'b0, "d0_idle_busy", busy[0], 0);
    chk(oe_n[0] == 1'b0, "d0_idle_oe", oe_n[0], 0);
    fb[0] = 384'h10;
    push(0, 384'h10);
    wait_frames(0, 2, 200);
    repeat (100) tick();
    chk(frames_done[0] == 2, "d0_one_new_frame", frames_done[0], 2);
`else
    r = 0;
    fb[0] = 384'hA5;
    push(0, 384'hA5);
    push(0, 384'hA5);
    release_rst(0);
    wait_frames(0, 1, 200);
    wait_start(0, 200);
    repeat (9) tick();
    fb[0] = 384'h3C;
    push(0, 384'h3C);
    push(0, 384'h3C);
    wait_frames(0, 4, 400);
`endif
    nrst[0] = 1'b0;
  endtask

  task automatic stim1();
    int n;
    n = CONT ? 3 : 1;
    repeat (3) tick();
    chk_reset(1, "d1_reset");
    fb[1] = 384'hFF;
    for (int i = 0; i < n; i++) push(1, 384'hFF);
    release_rst(1);
    wait_frames(1, n, 200);
    nrst[1] = 1'b0;
  endtask

  task automatic stim2();
    logic [383:0] pat;
    pat = {12{32'hDEADBEEF}};
    repeat (3) tick();
    chk_reset(2, "d2_reset");
    fb[2] = 384'd1;
    push(2, 384'd1);
    release_rst(2);
    wait_frames(2, 1, 3300);
    fb[2] = 384'd2;
    push(2, 384'd2);
    wait_frames(2, 2, 3300);
    fb[2] = {384{1'b1}};
    wait_start(2, 200);
    repeat (1466) tick();
    chk(sdata[2] == 1'b1, "d2_sdata_pre_reset", sdata[2], 1);
    nrst[2] = 1'b0;
    #1;
    chk_reset(2, "d2_async_reset");
    fb[2] = pat;
    push(2, pat);
    repeat (3) @(negedge clk);
    release_rst(2);
    wait_frames(2, 3, 3300);
    nrst[2] = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int k = 0; k < 3; k++) begin
      nrst[k] = 1'b0;
      fb[k] = '0;
      frames_done[k] = 0;
      rises[k] = 0;
    end
    fork
      stim0();
      stim1();
      stim2();
    join
    repeat (5) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
